mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_1  input  1  requester 1 has a word to send; held until gnt_1.
REQ-005 data_1  input  32  requester 1 word; stable while req_1=1.
REQ-006 gnt_1  output  1  data_1 accepted this cycle.
REQ-007 req_2  input  1  requester 2 has a word to send; held until gnt_2.
REQ-008 data_2  input  32  requester 2 word; stable while req_2=1.
REQ-009 gnt_2  output  1  data_2 accepted this cycle.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_data  output  32  registered output word.
REQ-012 out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-013 out_src  output  1  source of out_data: 1 = requester 1, 0 = requester 2.
REQ-014 count_1, count_2  output  8 each  words accepted per requester, wrapping modulo 256.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE (out_valid=0), HOLD_1 (out_data from requester 1), HOLD_2 (out_data from requester 2).
REQ-016 Accept window SHALL be: state IDLE, or out_valid=1 and out_ready=1 in the same cycle.
REQ-017 In the accept window, a single request SHALL be granted; if both are requesting, the requester not granted most recently SHALL win. The priority pointer after reset SHALL favour requester 1.
REQ-018 gnt_x SHALL be combinational, high for exactly one cycle, and mutually exclusive; never high outside the accept window.
REQ-019 On a grant edge: out_data <= data_x via the internal 2:1 mux (sel_mux=1 selects requester 1); out_valid <= 1; out_src <= x; count_x <= count_x+1; priority pointer <= other requester; state <= HOLD_x.
REQ-020 Latency: req_x seen in IDLE -> gnt_x same cycle -> out_valid=1 the next cycle.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_src and state SHALL remain unchanged and no grant SHALL issue.
REQ-022 A transfer (out_valid and out_ready) with no request pending SHALL move the FSM to IDLE and clear out_valid the next cycle.
REQ-023 A transfer with a request pending SHALL grant in the same cycle with no bubble, giving sustained throughput of one word per cycle.
REQ-024 With both requesters requesting continuously and out_ready=1, grants SHALL strictly alternate 1,2,1,2.
REQ-025 count_x at 8'hFF SHALL wrap to 8'h00 on the next grant with no other side effect.
REQ-026 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-027 While rst=1: gnt_1=gnt_2=0 combinationally; on the edge: state=IDLE, out_valid=0, out_data=32'h0, out_src=1, count_1=count_2=8'h00, priority pointer favours requester 1.
REQ-028 Reset asserted during HOLD_x SHALL discard the held word, grant nothing, and not count it.

Structure
REQ-029 Package mux_pkg SHALL hold DATA_W=32, CNT_W=8 and the state enum (IDLE, HOLD_1, HOLD_2).
REQ-030 The 2:1 selection SHALL instantiate the existing mux sub-module (in_mux_1=data_1, in_mux_2=data_2, sel_mux from the arbiter); all other logic SHALL be in mux_arbiter.

Verification
REQ-031 Single: reset; req_1=1, data_1=32'hAABBCCDD, out_ready=1 -> gnt_1 in cycle 0; next cycle out_valid=1, out_data=AABBCCDD, out_src=1, count_1=1.
REQ-032 Contention: req_1 and req_2 held, data_2=32'h11223344, out_ready=1 -> grant order 1,2,1,2; out_data alternates AABBCCDD/11223344 on consecutive cycles with no gaps.
REQ-033 Backpressure: out_ready=0 for 5 cycles with both requesting -> out_data stable, gnt_1=gnt_2=0 throughout; raising out_ready -> transfer and next grant in the same cycle.
REQ-034 Wrap: 256 grants to requester 1 -> count_1 returns to 8'h00; count_2 unchanged.
REQ-035 Reset mid-hold: out_valid=1, out_ready=0, rst pulse -> next cycle out_valid=0, counts 0; with both requesting, requester 1 is granted first.
REQ-036 Idle return: one transfer then no requests -> state IDLE, out_valid=0 next cycle; ignored out_ready=1 produces no change.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared widths and FSM state encoding for the two-requester output arbiter.
package mux_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_1 = 2'd1,
    HOLD_2 = 2'd2
  } state_e;
endpackage

// File: rtl/mux.sv
// 2:1 word mux; sel_mux=1 passes in_mux_1, otherwise in_mux_2.
module mux
  import mux_pkg::*;
(
  input  logic [DATA_W-1:0] in_mux_1,
  input  logic [DATA_W-1:0] in_mux_2,
  input  logic              sel_mux,
  output logic [DATA_W-1:0] out_mux
);
  assign out_mux = sel_mux ? in_mux_1 : in_mux_2;
endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered output slot
// with valid/ready handshake; one word per cycle when the consumer keeps up.
module mux_arbiter
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_1,
  input  logic [DATA_W-1:0] data_1,
  output logic              gnt_1,
  input  logic              req_2,
  input  logic [DATA_W-1:0] data_2,
  output logic              gnt_2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_src,
  output logic [CNT_W-1:0]  count_1,
  output logic [CNT_W-1:0]  count_2
);
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                src_q, src_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;
  logic [CNT_W-1:0]    cnt2_q, cnt2_d;
  logic                fav1_q, fav1_d;   // 1: requester 1 wins a tie
  logic                accept;
  logic                sel_mux;
  logic [DATA_W-1:0]   mux_word;

  mux u_mux (
    .in_mux_1 (data_1),
    .in_mux_2 (data_2),
    .sel_mux  (sel_mux),
    .out_mux  (mux_word)
  );

  assign out_valid = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign count_1   = cnt1_q;
  assign count_2   = cnt2_q;

  // The slot frees up when empty or when its word leaves this cycle,
  // so a pending request can refill it without a bubble.
  always_comb begin
    accept  = !rst && (!out_valid || out_ready);
    gnt_1   = accept && req_1 && (!req_2 || fav1_q);
    gnt_2   = accept && req_2 && (!req_1 || !fav1_q);
    sel_mux = gnt_1;

    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    fav1_d  = fav1_q;

    if (gnt_1) begin
      state_d = HOLD_1;
      data_d  = mux_word;
      src_d   = 1'b1;
      cnt1_d  = cnt1_q + 1'b1;
      fav1_d  = 1'b0;
    end else if (gnt_2) begin
      state_d = HOLD_2;
      data_d  = mux_word;
      src_d   = 1'b0;
      cnt2_d  = cnt2_q + 1'b1;
      fav1_d  = 1'b1;
    end else if (accept && out_valid) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      src_q   <= 1'b1;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      fav1_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      fav1_q  <= fav1_d;
    end
  end
endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural reference.
module tb_mux_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_1, req_2, out_ready;
  logic [31:0] data_1, data_2;
  logic        gnt_1, gnt_2, out_valid, out_src;
  logic [31:0] out_data;
  logic [7:0]  count_1, count_2;

  int n_vec = 0;
  int n_bad = 0;

  mux_arbiter dut (
    .clk(clk), .rst(rst),
    .req_1(req_1), .data_1(data_1), .gnt_1(gnt_1),
    .req_2(req_2), .data_2(data_2), .gnt_2(gnt_2),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_src(out_src), .count_1(count_1), .count_2(count_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the output slot is either empty or holds one word; the
  // tie-break goes to whichever requester was not the last winner.
  logic        m_ok = 1'b0;
  logic        m_full;
  logic [31:0] m_word;
  logic        m_from1;
  int          m_n1, m_n2;
  int          m_last;       // 1 or 2: last winner; 2 after reset so 1 is favoured
  logic        g1_d = 1'b0, g2_d = 1'b0;

  always @(negedge clk) begin
    bit free, w1, w2;
    g1_d = gnt_1;
    g2_d = gnt_2;
    if (rst) begin
      chk("rst_gnt_1", {31'd0, gnt_1}, 32'd0);
      chk("rst_gnt_2", {31'd0, gnt_2}, 32'd0);
      m_ok = 1'b1; m_full = 1'b0; m_word = 32'd0; m_from1 = 1'b1;
      m_n1 = 0; m_n2 = 0; m_last = 2;
    end else if (m_ok) begin
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_full});
      chk("m_out_data",  out_data, m_word);
      chk("m_out_src",   {31'd0, out_src}, {31'd0, m_from1});
      chk("m_count_1",   {24'd0, count_1}, m_n1 % 256);
      chk("m_count_2",   {24'd0, count_2}, m_n2 % 256);
      free = !m_full || out_ready;
      w1 = free && req_1 && (!req_2 || m_last == 2);
      w2 = free && req_2 && (!req_1 || m_last == 1);
      chk("m_gnt_1", {31'd0, gnt_1}, {31'd0, w1});
      chk("m_gnt_2", {31'd0, gnt_2}, {31'd0, w2});
      if (w1) begin
        m_full = 1'b1; m_word = data_1; m_from1 = 1'b1; m_n1++; m_last = 1;
      end else if (w2) begin
        m_full = 1'b1; m_word = data_2; m_from1 = 1'b0; m_n2++; m_last = 2;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_1 = 0; req_2 = 0; out_ready = 0; data_1 = 0; data_2 = 0;
    step(); step();
    @(negedge clk);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_data",  out_data, 32'h0);
    chk("reset_src",   {31'd0, out_src}, 32'd1);
    chk("reset_cnt",   {count_1, count_2}, 32'd0);

    // single word, then idle return with ignored out_ready
    step(); rst = 0; req_1 = 1; data_1 = 32'hAABBCCDD; out_ready = 1;
    @(negedge clk);
    chk("single_gnt_1", {30'd0, gnt_1, gnt_2}, 32'd2);
    chk("single_valid_before", {31'd0, out_valid}, 32'd0);
    step(); req_1 = 0;
    @(negedge clk);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data",  out_data, 32'hAABBCCDD);
    chk("single_src",   {31'd0, out_src}, 32'd1);
    chk("single_cnt1",  {24'd0, count_1}, 32'd1);
    step();
    @(negedge clk);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("idle_ignored_ready", {23'd0, out_valid, count_1}, 32'd1);

    // contention from a fresh reset: 1,2,1,2 with no gaps
    step(); rst = 1;
    step(); rst = 0; req_1 = 1; req_2 = 1; data_2 = 32'h11223344;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_gnt", {30'd0, gnt_1, gnt_2}, (i % 2 == 0) ? 32'd2 : 32'd1);
      if (i > 0) begin
        chk("cont_valid", {31'd0, out_valid}, 32'd1);
        chk("cont_data", out_data, (i % 2 == 1) ? 32'hAABBCCDD : 32'h11223344);
      end
      step();
    end
    out_ready = 0;

    // backpressure for five cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_gnt", {30'd0, gnt_1, gnt_2}, 32'd0);
      chk("bp_data", out_data, 32'h11223344);
      step();
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_gnt", {30'd0, gnt_1, gnt_2}, 32'd2);
    step(); out_ready = 0;
    @(negedge clk);
    chk("bp_release_data", out_data, 32'hAABBCCDD);

    // reset while holding a word
    step(); rst = 1;
    @(negedge clk);
    chk("midrst_gnt", {30'd0, gnt_1, gnt_2}, 32'd0);
    step(); rst = 0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_cnt", {count_1, count_2}, 32'd0);
    chk("midrst_first", {30'd0, gnt_1, gnt_2}, 32'd2);

    // counter wrap: 256 grants to requester 1
    step(); rst = 1; req_2 = 0;
    step(); rst = 0; out_ready = 1;
    repeat (255) step();
    @(negedge clk);
    chk("wrap_ff", {24'd0, count_1}, 32'hFF);
    step(); req_1 = 0;
    @(negedge clk);
    chk("wrap_00", {count_1, count_2}, 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 149) == 0);
      if (!req_1 || g1_d) begin
        req_1 = $urandom_range(0, 2) != 0;
        data_1 = $urandom;
      end
      if (!req_2 || g2_d) begin
        req_2 = $urandom_range(0, 2) != 0;
        data_2 = $urandom;
      end
      out_ready = $urandom_range(0, 3) != 0;
    end
    step();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
